// File: rtl/spiking_neuron_nin.sv
`timescale 1ns/1ps
// spiking_neuron_nin: N-input spiking neuron with per-input time-state kernels,
// runtime weights/bias/barrier, wide wrap-free accumulator and delayed spike delivery.
// Optional feature macro: SPIKING_NEURON_SPIKE_COUNT_EN adds a saturating spike_count output.
module spiking_neuron_nin #(
   parameter int NEURON_ID      = -1,
   parameter int INPUTS_COUNT   = 4,
   parameter int INT_WIDTH      = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int CMD_WIDTH      = 8,
   parameter int STATE_SIZE     = 4,
   parameter int STATE_GOOD_MAX = 4,
   parameter int STATE_NULL     = 15,
   parameter int OUT_BARRIER    = ((1 << INT_WIDTH) - 1) / 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         addr,
   input  logic [CMD_WIDTH-1:0]          cmd,
   input  logic signed [2*INT_WIDTH-1:0] cmd_arg,
   input  logic [INPUTS_COUNT-1:0]       in,
   output logic                          out
`ifdef SPIKING_NEURON_SPIKE_COUNT_EN
   ,
   output logic [15:0]                   spike_count
`endif
);

   localparam int IW      = INT_WIDTH;
   localparam int DW      = 2 * INT_WIDTH;
   localparam int SW      = STATE_SIZE;
   localparam int INT_MAX = (1 << INT_WIDTH) - 1;
   localparam int AW      = 3 * INT_WIDTH + $clog2(INPUTS_COUNT + 2) + 1;

   localparam logic [ADDR_WIDTH-1:0] MY_ADDR     = ADDR_WIDTH'(NEURON_ID);
   localparam logic [CMD_WIDTH-1:0]  CMD_TICK    = '0;
   localparam logic [CMD_WIDTH-1:0]  CMD_DELAY   = {CMD_WIDTH{1'b1}};
   localparam logic [CMD_WIDTH-1:0]  CMD_BIAS    = CMD_DELAY - CMD_WIDTH'(1);
   localparam logic [CMD_WIDTH-1:0]  CMD_CLEAR   = CMD_DELAY - CMD_WIDTH'(2);
   localparam logic [CMD_WIDTH-1:0]  CMD_BARRIER = CMD_DELAY - CMD_WIDTH'(3);

   localparam logic [SW-1:0] ST_ZERO = '0;
   localparam logic [SW-1:0] ST_GOOD = SW'(STATE_GOOD_MAX);
   localparam logic [SW-1:0] ST_NULL = SW'(STATE_NULL);

   // Kernel shape 0.7, 1.0, 0.6, 0.3, 0.1 of full scale, truncated
   localparam logic [IW-1:0] K0 = IW'((INT_MAX * 7) / 10);
   localparam logic [IW-1:0] K1 = IW'(INT_MAX);
   localparam logic [IW-1:0] K2 = IW'((INT_MAX * 6) / 10);
   localparam logic [IW-1:0] K3 = IW'((INT_MAX * 3) / 10);
   localparam logic [IW-1:0] K4 = IW'(INT_MAX / 10);

   localparam logic signed [DW-1:0] W_RST     = DW'(INT_MAX / INPUTS_COUNT);
   localparam logic [IW-1:0]        BAR_RST   = IW'(OUT_BARRIER);
   localparam logic [IW-1:0]        DT_RST    = IW'(1);
   localparam logic signed [AW-1:0] INH_SCALE = AW'(INT_MAX * INPUTS_COUNT);

   function automatic logic [IW-1:0] kern(input logic [SW-1:0] s);
      logic [IW-1:0] k;
      case (s)
         SW'(0):  k = K0;
         SW'(1):  k = K1;
         SW'(2):  k = K2;
         SW'(3):  k = K3;
         SW'(4):  k = K4;
         default: k = '0;
      endcase
      return k;
   endfunction

   logic [SW-1:0]        state_q     [INPUTS_COUNT];
   logic [SW-1:0]        state_d     [INPUTS_COUNT];
   logic [SW-1:0]        state_adv   [INPUTS_COUNT];
   logic signed [DW-1:0] w_q         [INPUTS_COUNT];
   logic signed [DW-1:0] w_d         [INPUTS_COUNT];
   logic signed [AW-1:0] term        [INPUTS_COUNT];
   logic [SW-1:0]        state_out_q, state_out_d, state_out_adv;
   logic signed [DW-1:0] bias_q, bias_d;
   logic [IW-1:0]        dt_q, dt_d;
   logic [IW-1:0]        barrier_q, barrier_d;
   logic [IW-1:0]        cnt_q, cnt_d;
   logic                 out_q, out_d;
   logic signed [AW-1:0] acc;
   logic [IW-1:0]        sat;
   logic                 fire;
   logic                 unused_acc_frac;

   // Per-input state advance and weighted kernel contribution
   generate
      for (genvar gi = 0; gi < INPUTS_COUNT; gi++) begin : g_input
         assign state_adv[gi] = in[gi] ? ST_ZERO :
                                ((state_q[gi] < ST_GOOD) ? state_q[gi] + SW'(1) : ST_NULL);
         assign term[gi] = AW'($signed({1'b0, kern(state_adv[gi])})) * AW'(w_q[gi]);
      end
   endgenerate

   assign state_out_adv = (state_out_q < ST_GOOD) ? state_out_q + SW'(1) : ST_NULL;

   // Accumulate bias, self-inhibition and weighted inputs at full width, then saturate
   always_comb begin
      acc = (AW'(bias_q) <<< IW) - AW'(kern(state_out_adv)) * INH_SCALE;
      for (int i = 0; i < INPUTS_COUNT; i++) begin
         acc = acc + term[i];
      end
      if (acc[AW-1]) begin
         sat = '0;
      end else if (|acc[AW-2:DW]) begin
         sat = IW'(INT_MAX);
      end else begin
         sat = acc[DW-1:IW];
      end
   end

   // Fraction bits below the output scale are intentionally dropped
   assign unused_acc_frac = ^acc[IW-1:0];
   assign fire = (sat > barrier_q);

   // Next-state: configuration commands, CLEAR, or a neural tick
   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      state_out_d = state_out_q;
      bias_d      = bias_q;
      dt_d        = dt_q;
      barrier_d   = barrier_q;
      cnt_d       = cnt_q;
      out_d       = 1'b0;
      if (cmd != CMD_TICK) begin
         if (cmd == CMD_CLEAR) begin
            cnt_d       = '0;
            state_out_d = ST_NULL;
            for (int i = 0; i < INPUTS_COUNT; i++) begin
               state_d[i] = ST_NULL;
            end
         end else if (addr == MY_ADDR) begin
            if (cmd == CMD_DELAY) begin
               dt_d = cmd_arg[IW-1:0];
            end else if (cmd == CMD_BIAS) begin
               bias_d = cmd_arg;
            end else if (cmd == CMD_BARRIER) begin
               barrier_d = cmd_arg[IW-1:0];
            end else begin
               for (int i = 0; i < INPUTS_COUNT; i++) begin
                  if (cmd == CMD_WIDTH'(i + 1)) w_d[i] = cmd_arg;
               end
            end
         end
      end else begin
         state_d     = state_adv;
         state_out_d = state_out_adv;
         if (cnt_q != '0) begin
            // A spike is in flight: count it down, no integration meanwhile
            out_d = (cnt_q == IW'(1));
            cnt_d = cnt_q - IW'(1);
         end else if (fire) begin
            state_out_d = ST_ZERO;
            if (dt_q == '0) out_d = 1'b1;
            else            cnt_d = dt_q;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= 1'b0;
         cnt_q       <= '0;
         state_out_q <= ST_NULL;
         bias_q      <= '0;
         dt_q        <= DT_RST;
         barrier_q   <= BAR_RST;
         for (int i = 0; i < INPUTS_COUNT; i++) begin
            state_q[i] <= ST_NULL;
            w_q[i]     <= W_RST;
         end
      end else begin
         out_q       <= out_d;
         cnt_q       <= cnt_d;
         state_out_q <= state_out_d;
         bias_q      <= bias_d;
         dt_q        <= dt_d;
         barrier_q   <= barrier_d;
         state_q     <= state_d;
         w_q         <= w_d;
      end
   end

   assign out = out_q;

`ifdef SPIKING_NEURON_SPIKE_COUNT_EN
   logic [15:0] spike_cnt_q, spike_cnt_d;

   // Saturating count of emitted spikes, cleared with CLEAR
   always_comb begin
      spike_cnt_d = spike_cnt_q;
      if (cmd == CMD_CLEAR) begin
         spike_cnt_d = '0;
      end else if (out_d && (spike_cnt_q != 16'hFFFF)) begin
         spike_cnt_d = spike_cnt_q + 16'd1;
      end
   end

   // Spike counter register
   always_ff @(posedge clk) begin
      if (rst) spike_cnt_q <= '0;
      else     spike_cnt_q <= spike_cnt_d;
   end

   assign spike_count = spike_cnt_q;
`endif

endmodule

// File: tb/tb_spiking_neuron_nin.sv
`timescale 1ns/1ps
// Scoreboard bench for spiking_neuron_nin: the driver runs a tick/age-based reference
// model and queues the expected output per edge; a monitor pops and compares.
module tb_spiking_neuron_nin;

   localparam int         N       = 4;
   localparam logic [7:0] ID      = 8'hFF;
   localparam logic [7:0] C_DELAY = 8'hFF;
   localparam logic [7:0] C_BIAS  = 8'hFE;
   localparam logic [7:0] C_CLEAR = 8'hFD;
   localparam logic [7:0] C_BAR   = 8'hFC;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  addr;
   logic [7:0]  cmd;
   logic [15:0] cmd_arg;
   logic [3:0]  in_s;
   logic        out_s;
`ifdef SPIKING_NEURON_SPIKE_COUNT_EN
   logic [15:0] spike_count;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct { bit o; int cnt; } exp_t;
   exp_t exp_q[$];

   // reference model state: age = ticks since last spike (-1 = idle)
   int     m_age[N];
   int     m_age_out;
   longint m_w[N];
   longint m_bias;
   int     m_dt, m_bar, m_pend, m_cnt;
   bit     m_out;

   spiking_neuron_nin dut (
      .clk(clk), .rst(rst), .addr(addr), .cmd(cmd), .cmd_arg(cmd_arg),
      .in(in_s), .out(out_s)
`ifdef SPIKING_NEURON_SPIKE_COUNT_EN
      , .spike_count(spike_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic longint kval(int age);
      case (age)
         0: return 178;
         1: return 255;
         2: return 153;
         3: return 76;
         4: return 25;
         default: return 0;
      endcase
   endfunction

   function automatic int next_age(int age, bit spk);
      if (spk) return 0;
      if (age >= 0 && age < 4) return age + 1;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_age[i] = -1;
         m_w[i]   = 63;
      end
      m_age_out = -1; m_bias = 0; m_dt = 1; m_bar = 127;
      m_pend = 0; m_out = 0; m_cnt = 0;
   endtask

   task automatic model_edge(bit r, logic [7:0] a, logic [7:0] c, logic [15:0] arg, logic [3:0] inb);
      longint acc;
      longint sat;
      if (r) begin
         model_reset();
         return;
      end
      m_out = 0;
      if (c != 8'd0) begin
         if (c == C_CLEAR) begin
            m_pend = 0; m_cnt = 0; m_age_out = -1;
            for (int i = 0; i < N; i++) m_age[i] = -1;
         end else if (a == ID) begin
            if (c >= 8'd1 && c <= 8'd4) m_w[c-1] = longint'($signed(arg));
            else if (c == C_DELAY) m_dt = int'(arg[7:0]);
            else if (c == C_BIAS)  m_bias = longint'($signed(arg));
            else if (c == C_BAR)   m_bar = int'(arg[7:0]);
         end
      end else begin
         for (int i = 0; i < N; i++) m_age[i] = next_age(m_age[i], inb[i]);
         m_age_out = next_age(m_age_out, 1'b0);
         if (m_pend > 0) begin
            m_out = (m_pend == 1);
            m_pend--;
         end else begin
            acc = m_bias * 256 - kval(m_age_out) * 255 * N;
            for (int i = 0; i < N; i++) acc += kval(m_age[i]) * m_w[i];
            if (acc < 0)           sat = 0;
            else if (acc >= 65536) sat = 255;
            else                   sat = acc / 256;
            if (sat > m_bar) begin
               m_age_out = 0;
               if (m_dt == 0) m_out = 1;
               else           m_pend = m_dt;
            end
         end
      end
      if (m_out && m_cnt < 65535) m_cnt++;
   endtask

   task automatic drive(bit r, logic [7:0] a, logic [7:0] c, logic [15:0] arg, logic [3:0] inb);
      exp_t e;
      @(negedge clk);
      rst = r; addr = a; cmd = c; cmd_arg = arg; in_s = inb;
      model_edge(r, a, c, arg, inb);
      e.o = m_out; e.cnt = m_cnt;
      exp_q.push_back(e);
      if (r) $display("t=%0t reset", $time);
      else if (c != 8'd0) $display("t=%0t cmd=%02h addr=%02h arg=%04h", $time, c, a, arg);
   endtask

   task automatic cfg(logic [7:0] c, logic [15:0] arg);
      drive(1'b0, ID, c, arg, 4'h0);
   endtask

   task automatic tick(logic [3:0] inb);
      drive(1'b0, 8'h00, 8'h00, 16'h0000, inb);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick(4'h0);
   endtask

   task automatic do_reset();
      drive(1'b1, 8'h00, 8'h00, 16'h0000, 4'h0);
   endtask

   // monitor: one expected entry per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_s !== e.o) begin
               errors++;
               $display("FAIL out t=%0t got=%b want=%b", $time, out_s, e.o);
            end else if (out_s === 1'b1) begin
               $display("t=%0t spike observed", $time);
            end
`ifdef SPIKING_NEURON_SPIKE_COUNT_EN
            checks++;
            if (spike_count !== 16'(e.cnt)) begin
               errors++;
               $display("FAIL spike_count t=%0t got=%0d want=%0d", $time, spike_count, e.cnt);
            end
`endif
         end
      end
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  c;
      logic [7:0]  a;
      logic [15:0] arg;
      logic [3:0]  inb;
      int          v;
      int          sel;
      rst = 1'b1; addr = 8'h00; cmd = 8'h00; cmd_arg = 16'h0000; in_s = 4'h0;
      model_reset();
      do_reset(); do_reset();
      ticks(2);

      // two strong inputs, default delivery of one tick
      cfg(8'd1, 16'd128); cfg(8'd2, 16'd128);
      tick(4'b0011); ticks(4);

      // default weights, single held input
      do_reset();
      for (int i = 0; i < 8; i++) tick(4'b0001);
      ticks(3);

      // immediate delivery, then inhibition with a held input
      do_reset();
      cfg(C_DELAY, 16'd0); cfg(8'd3, 16'd255);
      tick(4'b0100); tick(4'b0100); tick(4'b0100); ticks(3);

      // extreme bias values
      do_reset();
      cfg(C_BIAS, 16'h7FFF); ticks(4);
      cfg(C_BIAS, 16'hFF00);
      for (int i = 1; i <= 4; i++) cfg(8'(i), 16'd255);
      tick(4'hF); ticks(4);

      // raised barrier
      do_reset();
      cfg(C_BAR, 16'd200); cfg(8'd1, 16'd128); cfg(8'd2, 16'd128);
      tick(4'b0011); ticks(3);
      cfg(8'd1, 16'd255); cfg(8'd2, 16'd255);
      tick(4'b0011); ticks(4);

      // long delivery: CLEAR (broadcast from another address) cancels it
      do_reset();
      cfg(C_DELAY, 16'd5); cfg(8'd1, 16'd255); cfg(8'd2, 16'd255);
      tick(4'b0011); ticks(2);
      drive(1'b0, 8'h12, C_CLEAR, 16'h0000, 4'h0);
      ticks(7);
      // commands freeze delivery; foreign-address and unknown commands are ignored
      tick(4'b0011); tick(4'h0);
      drive(1'b0, 8'h05, 8'd1, 16'h0000, 4'h0);
      cfg(8'd100, 16'h1234);
      ticks(6);
      // reset mid-delivery
      tick(4'b0011); ticks(2);
      do_reset();
      ticks(7);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 1) begin
            do_reset();
         end else if (sel < 12) begin
            a = ($urandom_range(0, 99) < 85) ? ID : 8'($urandom_range(0, 254));
            case ($urandom_range(0, 9))
               4: begin c = C_DELAY; arg = 16'($urandom_range(0, 6)); end
               5: begin c = C_BIAS; v = int'($urandom_range(0, 120)) - 60; arg = 16'(v); end
               6: begin c = C_BAR;  arg = 16'($urandom_range(0, 255)); end
               7: begin c = C_CLEAR; arg = 16'h0; end
               8: begin c = 8'($urandom_range(5, 251)); arg = 16'($urandom); end
               default: begin
                  c = 8'($urandom_range(1, 4));
                  v = int'($urandom_range(0, 600)) - 100;
                  arg = 16'(v);
               end
            endcase
            drive(1'b0, a, c, arg, 4'h0);
         end else begin
            for (int i = 0; i < N; i++) inb[i] = ($urandom_range(0, 3) == 0);
            tick(inb);
         end
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
